// File: rtl/dpsk_pkg.sv
// Shared constants for the differential PSK mapper: mode codes, phase increments, cosine table.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package dpsk_pkg;

  // Carrier phase is kept in 22.5 degree steps, 16 positions per turn
  localparam int PHASE_W = 4;

  typedef logic [PHASE_W-1:0] phase_t;

  typedef enum logic [1:0] {
    MODE_DBPSK    = 2'd0,
    MODE_DQPSK    = 2'd1,
    MODE_PI4DQPSK = 2'd2,
    MODE_D8PSK    = 2'd3
  } mode_t;

  // Gray-mapped phase increments, indexed directly by the symbol bits
  localparam phase_t INC_DBPSK    [2] = '{4'd0, 4'd8};
  localparam phase_t INC_DQPSK    [4] = '{4'd0, 4'd4, 4'd12, 4'd8};
  localparam phase_t INC_PI4DQPSK [4] = '{4'd2, 4'd14, 4'd6, 4'd10};
  localparam phase_t INC_D8PSK    [8] = '{4'd0, 4'd2, 4'd6, 4'd4, 4'd14, 4'd12, 4'd8, 4'd10};

  // Quarter-wave cosine at 0, 22.5, 45, 67.5, 90 degrees, full-scale 16-bit
  localparam logic [15:0] QW_TABLE [5] = '{16'd32767, 16'd30273, 16'd23170, 16'd12539, 16'd0};

  // Phase step for one symbol; bits above the mode's symbol width are ignored
  function automatic phase_t phase_inc(input mode_t m, input logic [2:0] d);
    phase_t inc;
    case (m)
      MODE_DBPSK:    inc = INC_DBPSK[d[0]];
      MODE_DQPSK:    inc = INC_DQPSK[d[1:0]];
      MODE_PI4DQPSK: inc = INC_PI4DQPSK[d[1:0]];
      default:       inc = INC_D8PSK[d];
    endcase
    return inc;
  endfunction

  // Stage-1 register: freshly accumulated phase plus its valid flag
  typedef struct packed {
    logic   vld;
    phase_t phase;
  } stage_t;

endpackage

// File: rtl/psk_sincos_lut.sv
// Maps a 16-position carrier phase to signed cos/sin samples via quarter-wave symmetry.
// Latency: combinational, zero cycles.
// Backpressure: none; purely combinational.
module psk_sincos_lut
  import dpsk_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic [PHASE_W-1:0]      phase,
  output logic signed [OUT_W-1:0] cos_val,
  output logic signed [OUT_W-1:0] sin_val
);

  // Table entry scaled down to the output width before any sign is applied,
  // so positive and negative peaks have the same magnitude
  function automatic logic signed [OUT_W-1:0] qscale(input logic [2:0] k);
    logic signed [15:0] s;
    s = $signed(QW_TABLE[k]) >>> (16 - OUT_W);
    return s[OUT_W-1:0];
  endfunction

  // Fold the phase into the first quadrant and pick the sign of the result
  function automatic logic signed [OUT_W-1:0] cos_of(input phase_t p);
    logic [3:0] idx;
    logic       neg;
    logic signed [OUT_W-1:0] mag;
    if (p <= 4'd4) begin
      idx = p;
      neg = 1'b0;
    end else if (p <= 4'd8) begin
      idx = 4'd8 - p;
      neg = 1'b1;
    end else if (p <= 4'd12) begin
      idx = p - 4'd8;
      neg = 1'b1;
    end else begin
      idx = 4'd0 - p;   // 16 - p, modulo 16
      neg = 1'b0;
    end
    mag = qscale(idx[2:0]);
    return neg ? -mag : mag;
  endfunction

  // sin is cos delayed by a quarter turn (four phase steps)
  always_comb begin
    cos_val = cos_of(phase);
    sin_val = cos_of(phase - 4'd4);
  end

endmodule

// File: rtl/dpsk_symbol_mapper.sv
// Differential PSK mapper: accumulates carrier phase per symbol and emits signed I/Q.
// Latency: 2 clk from accepted symbol to out_valid; 1 symbol/clk sustained.
// Backpressure: out_valid && !out_ready freezes the whole pipeline and drops in_ready.
module dpsk_symbol_mapper
  import dpsk_pkg::*;
#(
  parameter int OUT_W = 8,
  parameter int PH_W  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic [1:0]              mode,
  input  logic [2:0]              din,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] out_i,
  output logic signed [OUT_W-1:0] out_q,
  output logic [PH_W-1:0]         out_phase,
  output logic                    out_valid,
  input  logic                    out_ready
);

  if (PH_W != PHASE_W) begin : g_bad_ph_w
    $error("dpsk_symbol_mapper: PH_W must equal the package phase width");
  end
  if (OUT_W < 4 || OUT_W > 16) begin : g_bad_out_w
    $error("dpsk_symbol_mapper: OUT_W must lie in 4..16");
  end

  logic   en;
  logic   accept;
  phase_t acc;
  phase_t acc_next;
  stage_t s1;

  logic signed [OUT_W-1:0] lut_cos;
  logic signed [OUT_W-1:0] lut_sin;

  // Pipeline advances whenever the output slot is empty or being drained
  always_comb begin
    en       = !out_valid || out_ready;
    in_ready = en;
    accept   = in_valid && en;
    acc_next = acc + phase_inc(mode_t'(mode), din);
  end

  // Phase accumulator: moves only on an accepted symbol, wraps modulo 16
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         acc <= '0;
    else if (clr)    acc <= '0;
    else if (accept) acc <= acc_next;
  end

  // Stage 1: capture the new phase; a bubble is inserted when nothing is accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
    end else if (clr) begin
      s1.vld <= 1'b0;
    end else if (en) begin
      s1.vld <= accept;
      if (accept) s1.phase <= acc_next;
    end
  end

  psk_sincos_lut #(
    .OUT_W (OUT_W)
  ) u_lut (
    .phase   (s1.phase),
    .cos_val (lut_cos),
    .sin_val (lut_sin)
  );

  // Stage 2: output register; data only reloads on a real symbol so idle output stays put
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_i     <= '0;
      out_q     <= '0;
      out_phase <= '0;
      out_valid <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= s1.vld;
      if (s1.vld) begin
        out_i     <= lut_cos;
        out_q     <= lut_sin;
        out_phase <= s1.phase;
      end
    end
  end

endmodule

// File: doc/dpsk_symbol_mapper.md
Name: dpsk_symbol_mapper

Overview:
- Parametrised differential PSK symbol mapper.
- Accepts 1–3 bit symbols over a valid/ready handshake and accumulates a 16-position carrier phase.
- Emits signed baseband I/Q from a quarter-wave cosine table.
- Run-time modes: DBPSK, DQPSK, π/4-DQPSK and D8PSK. Sits between the bit-to-symbol packer and the pulse-shaping FIR in the modulator transmit path.

Parameters:
- OUT_W, 8, signed I/Q output width; legal range 4..16.
- PH_W, 4, phase accumulator width; fixed at 4 (16 phases), exposed for the package check only.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- clr  in  1  synchronous clear; zeroes the phase accumulator and flushes pipeline valids
- mode  in  2  0=DBPSK, 1=DQPSK, 2=π/4-DQPSK, 3=D8PSK; sampled with each accepted symbol
- din  in  3  symbol bits; DBPSK uses [0], DQPSK and π/4-DQPSK use [1:0], D8PSK uses [2:0]
- in_valid  in  1  din is valid
- in_ready  out  1  mapper can accept a symbol this cycle
- out_i  out  OUT_W  signed in-phase sample
- out_q  out  OUT_W  signed quadrature sample
- out_phase  out  4  phase index of the current output (unit 22.5°)
- out_valid  out  1  out_i, out_q and out_phase are valid
- out_ready  in  1  downstream accepts the output

Behaviour:
- Reset values: phase accumulator 0, both stage valids 0, out_i=0, out_q=0, out_phase=0, out_valid=0.
- Pipeline enable: en = !out_valid || out_ready. in_ready = en; it is combinational and does not depend on in_valid.
- Accept: in_valid && in_ready.
  - On accept: acc <= acc + inc(mode, din), modulo 16. Stage 1 registers the new acc with valid=1.
  - On en without accept: stage-1 valid <= 0.
- Stage 2: on en, registers the LUT output of stage 1 into out_i, out_q and out_phase, with out_valid <= stage-1 valid. Latency is 2 clk from accept to out_valid when there is no backpressure. Throughput is 1 symbol per clk.
- Stall: when en=0 every register holds its value. No symbol is lost or duplicated.
- Increment tables, in 22.5° units, Gray mapped:
  - DBPSK: din[0] 0→0, 1→8.
  - DQPSK: 00→0, 01→4, 11→8, 10→12.
  - π/4-DQPSK: 00→2, 01→14, 10→6, 11→10.
  - D8PSK: 000→0, 001→2, 011→4, 010→6, 110→8, 111→10, 101→12, 100→14.
- Unused din bits are ignored.
- Mode may change between any two accepted symbols. The accumulator is not reset on a mode change.
- Wrap-around: acc is 4-bit unsigned and wraps naturally, e.g. 14+6 → 4.
- LUT: Q[0..4] = 32767, 30273, 23170, 12539, 0 (cos k·22.5°, 16-bit). Each entry is scaled as Q[k] >>> (16-OUT_W).
- cos(p) by phase range:
  - p 0..4: +Q[p]
  - p 5..8: −Q[8−p]
  - p 9..12: −Q[p−8]
  - p 13..15: +Q[16−p]
- sin(p) = cos((p−4) mod 16). Negation is applied after scaling, so the output is symmetric: no −2^(OUT_W−1) value is ever produced.
- clr: priority is rst > clr > accept.
  - clr clears acc to 0 and both valids to 0 regardless of en. An in_valid symbol presented in the clr cycle is dropped.
  - in_ready during clr follows en.
- rst mid-stream: an asynchronous return to reset values. In-flight symbols are discarded.

Decomposition:
- Package dpsk_pkg holds:
  - mode encodings (MODE_DBPSK..MODE_D8PSK)
  - the four increment lookup constants
  - the 5-entry 16-bit quarter-wave table Q
  - the phase width constant 4
- Sub-module psk_sincos_lut: combinational phase(4) → signed cos/sin(OUT_W) using the package table. It is instantiated once between stage 1 and stage 2.

Test Plan:
- Reset, then idle → out_i=0, out_q=0, out_phase=0, out_valid=0, in_ready=1.
- OUT_W=8, mode=2, din=00 ×4 back-to-back, out_ready=1 → 2 clk after the first accept the outputs are (90,90), (0,127), (−90,90), (−127,0), with out_phase 2, 4, 6, 8.
- mode=3, din=100 ×3 → phases 14, 12, 10 → (90,−90), (90,−90)→(0,−127)… checked exactly against the table. Then din=110 from phase 10 → wraps to 2 → (90,90).
- Backpressure: stream 6 DQPSK symbols of din=01 while out_ready is held low for 4 clk → in_ready=0 while out_valid=1 && !out_ready. The output sequence is phases 4, 8, 12, 0, 4, 8 in order, with no loss or duplication.
- clr asserted after 3 symbols, with in_valid high in the same cycle → out_valid=0 next cycle. The next accepted DBPSK din=1 gives phase 8, (−127,0).
- OUT_W=12, mode=2, din=00 → (1448,1448). Then din=01 → phase 0 → (2047,0).
